// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the branch target buffer update path.
//   btb_update_t : one queued branch resolution (index, tag, direction, target word)
//   btb_state_t  : read-port arbitration state of the BTB controller
//   sat_inc/sat_dec : 2-bit saturating direction counter steps
package branch_pred_pkg;

  // Address split of a word-aligned PC.
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = 3;
  localparam int TAG_LSB = 4;
  localparam int TAG_MSB = 31;
  localparam int TGT_LSB = 2;
  localparam int TGT_MSB = 31;

  typedef struct packed {
    logic [1:0]  idx;
    logic [27:0] tag;
    logic        taken;
    logic [29:0] target;
  } btb_update_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } btb_state_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] h);
    return (h == 2'b11) ? 2'b11 : h + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] h);
    return (h == 2'b00) ? 2'b00 : h - 2'b01;
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Synchronous FIFO holding branch resolutions until the BTB read port is free.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_wdata   write an entry (ignored while full)
//   i_pop             drop the head entry (ignored while empty)
//   o_rdata           head entry (valid while !o_empty)
//   o_full, o_empty   occupancy flags
module btb_update_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 61
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW + 1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW + 1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/btb_controller.sv
// Branch target buffer controller: serves fetch lookups on the BTB read port,
// queues execute-stage resolutions and applies each one as a read-modify-write
// of the 2-bit direction counter, borrowing the read port from fetch when needed.
// Ports:
//   CLK, nRST                       clock, asynchronous active-low reset
//   fetch_req/fetch_pc              fetch lookup; fetch_stall = read port lent to an update
//   pred_taken/pred_target          same-cycle prediction
//   res_valid/res_ready/res_*       branch resolution handshake from execute
//   btb_sel/btb_tag <- btb_hit/btb_hist/btb_target   BTB read port
//   btb_wen/btb_wsel/btb_wtag/btb_wtarget/btb_wvalid/btb_whist   BTB write port
module btb_controller
  import branch_pred_pkg::*;
#(
  parameter int QDEPTH   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_stall,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic [1:0]  btb_sel,
  output logic [27:0] btb_tag,
  input  logic        btb_hit,
  input  logic [1:0]  btb_hist,
  input  logic [29:0] btb_target,
  output logic        btb_wen,
  output logic [1:0]  btb_wsel,
  output logic [27:0] btb_wtag,
  output logic [29:0] btb_wtarget,
  output logic        btb_wvalid,
  output logic [1:0]  btb_whist
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  btb_state_t        r_state;
  btb_state_t        w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        r_wsel;
  logic [27:0]       r_wtag;
  logic [29:0]       r_wtarget;
  logic [1:0]        r_whist;

  btb_update_t       w_entry;
  btb_update_t       w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_go_rd;
  logic              w_in_rd;
  logic [1:0]        w_new_hist;
  logic [29:0]       w_new_target;
  logic              w_unused;

  assign w_entry = '{idx:    res_pc[IDX_MSB:IDX_LSB],
                     tag:    res_pc[TAG_MSB:TAG_LSB],
                     taken:  res_taken,
                     target: res_target[TGT_MSB:TGT_LSB]};
  assign w_unused = ^{res_pc[1:0], res_target[1:0]};

  btb_update_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(btb_update_t))
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_push  (res_valid),
    .i_wdata (w_entry),
    .i_pop   (w_in_rd),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign res_ready = ~w_full;
  assign w_in_rd   = (r_state == RD);

  // Take the read port when fetch is idle, when execute is being back-pressured,
  // or when the head has waited long enough.
  assign w_go_rd = (r_state == IDLE) && !w_empty &&
                   (!fetch_req || w_full || (r_wait == WAIT_W'(MAX_WAIT)));

  // Read port: the queue head owns it only during RD.
  assign btb_sel     = w_in_rd ? w_head.idx : fetch_pc[IDX_MSB:IDX_LSB];
  assign btb_tag     = w_in_rd ? w_head.tag : fetch_pc[TAG_MSB:TAG_LSB];
  assign fetch_stall = w_in_rd & fetch_req;
  assign pred_taken  = ~w_in_rd & fetch_req & btb_hit & btb_hist[1];
  assign pred_target = pred_taken ? {btb_target, 2'b00} : fetch_pc + 32'd4;

  // New entry contents from the RD-cycle read; a miss can only reach here when taken.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_new_hist   = 2'b10;
    w_new_target = w_head.target;
    if (btb_hit) begin
      if (w_head.taken) begin
        w_new_hist = sat_inc(btb_hist);
      end else begin
        w_new_hist   = sat_dec(btb_hist);
        w_new_target = btb_target;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go_rd) w_next = RD;
      RD:      w_next = (!btb_hit && !w_head.taken) ? IDLE : WR;
      WR:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_wsel    <= '0;
      r_wtag    <= '0;
      r_wtarget <= '0;
      r_whist   <= '0;
    end else begin
      r_state <= w_next;
      if (w_go_rd) begin
        r_wait <= '0;
      end else if (r_state == IDLE && !w_empty && r_wait != WAIT_W'(MAX_WAIT)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_in_rd) begin
        r_wsel    <= w_head.idx;
        r_wtag    <= w_head.tag;
        r_wtarget <= w_new_target;
        r_whist   <= w_new_hist;
      end
    end
  end

  // Write port is driven straight from state so reset aborts a write immediately.
  assign btb_wen     = (r_state == WR);
  assign btb_wvalid  = (r_state == WR);
  assign btb_wsel    = r_wsel;
  assign btb_wtag    = r_wtag;
  assign btb_wtarget = r_wtarget;
  assign btb_whist   = r_whist;

endmodule

// File: tb/tb_btb_controller.sv
// Self-checking bench for btb_controller. A behavioural BTB storage array serves
// the read port and absorbs the write port; an independent reference table plus a
// queue of accepted resolutions predicts every prediction and every write.
module tb_btb_controller;

  localparam int QDEPTH   = 2;
  localparam int MAX_WAIT = 8;

  logic        CLK;
  logic        nRST;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic [1:0]  btb_sel;
  logic [27:0] btb_tag;
  logic        btb_hit;
  logic [1:0]  btb_hist;
  logic [29:0] btb_target;
  logic        btb_wen;
  logic [1:0]  btb_wsel;
  logic [27:0] btb_wtag;
  logic [29:0] btb_wtarget;
  logic        btb_wvalid;
  logic [1:0]  btb_whist;

  btb_controller #(.QDEPTH(QDEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target),
    .btb_sel(btb_sel), .btb_tag(btb_tag), .btb_hit(btb_hit),
    .btb_hist(btb_hist), .btb_target(btb_target),
    .btb_wen(btb_wen), .btb_wsel(btb_wsel), .btb_wtag(btb_wtag),
    .btb_wtarget(btb_wtarget), .btb_wvalid(btb_wvalid), .btb_whist(btb_whist)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Storage array seen by the DUT.
  logic        mem_v   [4] = '{default: 1'b0};
  logic [27:0] mem_tag [4] = '{default: 28'h0};
  logic [1:0]  mem_hist[4] = '{default: 2'b00};
  logic [29:0] mem_tgt [4] = '{default: 30'h0};

  always_comb begin
    btb_hit    = mem_v[btb_sel] && (mem_tag[btb_sel] == btb_tag);
    btb_hist   = mem_hist[btb_sel];
    btb_target = mem_tgt[btb_sel];
  end

  // Reference model: expected table contents and resolutions accepted but not yet applied.
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } res_t;

  logic        ref_v   [4] = '{default: 1'b0};
  logic [27:0] ref_tag [4] = '{default: 28'h0};
  logic [1:0]  ref_hist[4] = '{default: 2'b00};
  logic [29:0] ref_tgt [4] = '{default: 30'h0};
  res_t        ref_q[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_writes = 0;
  logic [1:0]  last_wsel;
  logic [27:0] last_wtag;
  logic [1:0]  last_whist;
  logic [29:0] last_wtgt;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd4);
  endfunction

  function automatic bit ref_hit(input logic [31:0] pc);
    int i;
    i = slot_of(pc);
    return ref_v[i] && (ref_tag[i] == 28'(pc >> 4));
  endfunction

  // A resolution changes the table unless it is a not-taken branch the table does not know.
  function automatic bit ref_writes(input res_t r);
    return ref_hit(r.pc) || r.taken;
  endfunction

  task automatic storage_loop();
    forever begin
      @(posedge CLK);
      if (nRST && btb_wen) begin
        mem_v[btb_wsel]    <= btb_wvalid;
        mem_tag[btb_wsel]  <= btb_wtag;
        mem_hist[btb_wsel] <= btb_whist;
        mem_tgt[btb_wsel]  <= btb_wtarget;
      end
    end
  endtask

  task automatic monitor();
    int          i;
    int          h;
    logic        exp_t;
    logic [31:0] exp_pt;
    logic [1:0]  exp_h;
    logic [29:0] exp_w;
    res_t        r;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        ref_q.delete();
      end else begin
        // Prediction against the table as it stands before any write this cycle.
        if (fetch_req && !fetch_stall) begin
          i      = slot_of(fetch_pc);
          exp_t  = ref_hit(fetch_pc) && ref_hist[i][1];
          exp_pt = exp_t ? (32'(ref_tgt[i]) * 32'd4) : (fetch_pc + 32'd4);
          n_checks++;
          if (pred_taken !== exp_t || pred_target !== exp_pt)
            $display("FAIL predict pc=%h got taken=%b target=%h expected taken=%b target=%h",
                     fetch_pc, pred_taken, pred_target, exp_t, exp_pt);
          else n_pass++;
        end else if (!fetch_req) begin
          n_checks++;
          if (pred_taken !== 1'b0)
            $display("FAIL predict_idle got taken=%b expected 0", pred_taken);
          else n_pass++;
        end
        // Write-port check against the oldest resolution that should write.
        if (btb_wen) begin
          while (ref_q.size() > 0 && !ref_writes(ref_q[0])) void'(ref_q.pop_front());
          n_checks++;
          if (ref_q.size() == 0) begin
            $display("FAIL write_unexpected sel=%0d tag=%h hist=%b", btb_wsel, btb_wtag, btb_whist);
          end else begin
            r = ref_q.pop_front();
            i = slot_of(r.pc);
            h = int'(ref_hist[i]);
            if (!ref_hit(r.pc)) begin
              exp_h = 2'b10;
              exp_w = 30'(r.target >> 2);
            end else if (r.taken) begin
              exp_h = 2'((h == 3) ? 3 : h + 1);
              exp_w = 30'(r.target >> 2);
            end else begin
              exp_h = 2'((h == 0) ? 0 : h - 1);
              exp_w = ref_tgt[i];
            end
            if (btb_wsel !== 2'(i) || btb_wtag !== 28'(r.pc >> 4) || btb_whist !== exp_h ||
                btb_wtarget !== exp_w || btb_wvalid !== 1'b1)
              $display("FAIL write pc=%h got sel=%0d tag=%h hist=%b tgt=%h v=%b expected sel=%0d tag=%h hist=%b tgt=%h v=1",
                       r.pc, btb_wsel, btb_wtag, btb_whist, btb_wtarget, btb_wvalid,
                       i, 28'(r.pc >> 4), exp_h, exp_w);
            else n_pass++;
            ref_v[i]    = 1'b1;
            ref_tag[i]  = 28'(r.pc >> 4);
            ref_hist[i] = exp_h;
            ref_tgt[i]  = exp_w;
          end
          last_wsel  = btb_wsel;
          last_wtag  = btb_wtag;
          last_whist = btb_whist;
          last_wtgt  = btb_wtarget;
          n_writes++;
        end
        // Accepted this cycle; enters the queue at the next edge.
        if (res_valid && res_ready) ref_q.push_back('{pc: res_pc, taken: res_taken, target: res_target});
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    int guard;
    guard = 0;
    while (!res_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!res_ready) begin
      n_checks++;
      $display("FAIL push_timeout pc=%h res_ready stayed %b, expected 1", pc, res_ready);
    end
    res_valid  = 1'b1;
    res_pc     = pc;
    res_taken  = t;
    res_target = tgt;
    tick();
    res_valid  = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (2 * (MAX_WAIT + 4) * QDEPTH) tick();
    while (ref_q.size() > 0 && !ref_writes(ref_q[0])) void'(ref_q.pop_front());
    n_checks++;
    if (ref_q.size() != 0)
      $display("FAIL %s_drain pending=%0d expected 0", name, ref_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (btb_wen !== 1'b0 || fetch_stall !== 1'b0 || pred_taken !== 1'b0 || res_ready !== 1'b1)
      $display("FAIL reset_ctrl got wen=%b stall=%b taken=%b ready=%b expected 0 0 0 1",
               btb_wen, fetch_stall, pred_taken, res_ready);
    else n_pass++;
    n_checks++;
    if ({btb_wsel, btb_wtag, btb_wtarget, btb_wvalid, btb_whist} !== 63'h0)
      $display("FAIL reset_wfields got sel=%0d tag=%h tgt=%h v=%b hist=%b expected all 0",
               btb_wsel, btb_wtag, btb_wtarget, btb_wvalid, btb_whist);
    else n_pass++;
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_predict_empty();
    fetch_req = 1'b1;
    fetch_pc  = 32'h100;
    @(negedge CLK);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104 || fetch_stall !== 1'b0)
      $display("FAIL empty_predict got taken=%b target=%h stall=%b expected 0 00000104 0",
               pred_taken, pred_target, fetch_stall);
    else n_pass++;
    tick();
    fetch_req = 1'b0;
    fetch_pc  = 32'h0;
  endtask

  task automatic test_alloc();
    int w0;
    w0 = n_writes;
    push(32'h100, 1'b1, 32'h200);
    tick();
    n_checks++;
    if (btb_tag !== 28'h10 || btb_sel !== 2'd0 || btb_wen !== 1'b0)
      $display("FAIL alloc_rd got tag=%h sel=%0d wen=%b expected 0000010 0 0", btb_tag, btb_sel, btb_wen);
    else n_pass++;
    tick();
    n_checks++;
    if (btb_wen !== 1'b1)
      $display("FAIL alloc_wr got wen=%b expected 1", btb_wen);
    else n_pass++;
    drain("alloc");
    n_checks++;
    if (n_writes - w0 != 1 || last_wsel !== 2'd0 || last_wtag !== 28'h10 ||
        last_whist !== 2'b10 || last_wtgt !== 30'h80)
      $display("FAIL alloc_write got n=%0d sel=%0d tag=%h hist=%b tgt=%h expected 1 0 0000010 10 00000080",
               n_writes - w0, last_wsel, last_wtag, last_whist, last_wtgt);
    else n_pass++;
    fetch_req = 1'b1;
    fetch_pc  = 32'h100;
    @(negedge CLK);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200)
      $display("FAIL alloc_predict got taken=%b target=%h expected 1 00000200", pred_taken, pred_target);
    else n_pass++;
    tick();
    fetch_req = 1'b0;
    fetch_pc  = 32'h0;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_dn [3] = '{2'b10, 2'b01, 2'b00};
    for (int k = 0; k < 3; k++) begin
      push(32'h100, 1'b1, 32'h200);
      drain("sat_up");
      n_checks++;
      if (last_whist !== 2'b11)
        $display("FAIL sat_up%0d got hist=%b expected 11", k, last_whist);
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      push(32'h100, 1'b0, 32'h340);
      drain("sat_dn");
      n_checks++;
      if (last_whist !== exp_dn[k] || last_wtgt !== 30'h80)
        $display("FAIL sat_dn%0d got hist=%b tgt=%h expected %b 00000080", k, last_whist, last_wtgt, exp_dn[k]);
      else n_pass++;
    end
    fetch_req = 1'b1;
    fetch_pc  = 32'h100;
    @(negedge CLK);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104)
      $display("FAIL sat_predict got taken=%b target=%h expected 0 00000104", pred_taken, pred_target);
    else n_pass++;
    tick();
    fetch_req = 1'b0;
    fetch_pc  = 32'h0;
  endtask

  task automatic test_miss_no_write();
    int w0;
    int rd_seen;
    w0      = n_writes;
    rd_seen = 0;
    push(32'h300, 1'b0, 32'h400);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (btb_tag == 28'h30) rd_seen++;
    end
    n_checks++;
    if (rd_seen != 1 || n_writes != w0)
      $display("FAIL miss_nt got rd_cycles=%0d writes=%0d expected 1 0", rd_seen, n_writes - w0);
    else n_pass++;
    drain("miss_nt");
  endtask

  task automatic test_max_wait();
    int   first;
    int   n_stall;
    logic wen_next;
    first    = 0;
    n_stall  = 0;
    wen_next = 1'b0;
    fetch_req = 1'b1;
    fetch_pc  = 32'h500;
    tick();
    push(32'h140, 1'b1, 32'h600);
    for (int c = 1; c <= MAX_WAIT + 6; c++) begin
      @(negedge CLK);
      if (first != 0 && c == first + 1) wen_next = btb_wen;
      if (fetch_stall) begin
        if (first == 0) first = c;
        n_stall++;
      end
    end
    n_checks++;
    if (first <= MAX_WAIT || first > MAX_WAIT + 2)
      $display("FAIL max_wait_start got first_stall_cycle=%0d expected %0d..%0d", first, MAX_WAIT + 1, MAX_WAIT + 2);
    else n_pass++;
    n_checks++;
    if (n_stall != 1 || wen_next !== 1'b1)
      $display("FAIL max_wait_stall got stalls=%0d wen_after=%b expected 1 1", n_stall, wen_next);
    else n_pass++;
    tick();
    fetch_req = 1'b0;
    drain("max_wait");
  endtask

  task automatic test_back_to_back();
    int w0;
    int guard;
    push(32'h110, 1'b1, 32'h220);
    drain("b2b_seed");
    n_checks++;
    if (last_whist !== 2'b10 || last_wtag !== 28'h11)
      $display("FAIL b2b_seed got hist=%b tag=%h expected 10 0000011", last_whist, last_wtag);
    else n_pass++;
    fetch_req = 1'b1;
    fetch_pc  = 32'h700;
    w0 = n_writes;
    push(32'h110, 1'b1, 32'h220);
    push(32'h110, 1'b1, 32'h220);
    n_checks++;
    if (res_ready !== 1'b0)
      $display("FAIL b2b_full got res_ready=%b expected 0", res_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (fetch_stall !== 1'b1)
      $display("FAIL b2b_grant got stall=%b expected 1", fetch_stall);
    else n_pass++;
    guard = 0;
    while (n_writes - w0 < 2 && guard < 4 * (MAX_WAIT + 6)) begin
      tick();
      guard++;
    end
    n_checks++;
    if (n_writes - w0 != 2 || last_whist !== 2'b11)
      $display("FAIL b2b_result got writes=%0d hist=%b expected 2 11", n_writes - w0, last_whist);
    else n_pass++;
    fetch_req = 1'b0;
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    int w0;
    int guard;
    push(32'h120, 1'b1, 32'h240);
    guard = 0;
    while (!btb_wen && guard < 10) begin
      tick();
      guard++;
    end
    n_checks++;
    if (btb_wen !== 1'b1)
      $display("FAIL rst_mid_reach got wen=%b expected 1", btb_wen);
    else n_pass++;
    nRST = 1'b0;
    #1;
    n_checks++;
    if (btb_wen !== 1'b0 || fetch_stall !== 1'b0 || res_ready !== 1'b1 || btb_whist !== 2'b00)
      $display("FAIL rst_mid_abort got wen=%b stall=%b ready=%b hist=%b expected 0 0 1 00",
               btb_wen, fetch_stall, res_ready, btb_whist);
    else n_pass++;
    tick();
    nRST = 1'b1;
    tick();
    w0 = n_writes;
    fetch_req = 1'b1;
    fetch_pc  = 32'h700;
    push(32'h104, 1'b1, 32'h800);
    push(32'h108, 1'b1, 32'h900);
    nRST = 1'b0;
    #1;
    n_checks++;
    if (res_ready !== 1'b1)
      $display("FAIL rst_mid_flush got res_ready=%b expected 1", res_ready);
    else n_pass++;
    tick();
    nRST = 1'b1;
    fetch_req = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (n_writes != w0)
      $display("FAIL rst_mid_discard got writes=%0d expected 0", n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_random();
    int w0;
    w0 = n_writes;
    for (int c = 0; c < 400; c++) begin
      if (!fetch_stall) begin
        fetch_req = 1'($urandom_range(0, 1));
        fetch_pc  = 32'h1000 + (32'($urandom_range(0, 2)) << 4) + (32'($urandom_range(0, 3)) << 2);
      end
      res_valid  = ($urandom_range(0, 2) == 0);
      res_pc     = 32'h1000 + (32'($urandom_range(0, 2)) << 4) + (32'($urandom_range(0, 3)) << 2);
      res_taken  = 1'($urandom_range(0, 1));
      res_target = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    res_valid = 1'b0;
    fetch_req = 1'b0;
    drain("random");
    n_checks++;
    if (n_writes == w0)
      $display("FAIL random_activity got writes=0 expected >0");
    else n_pass++;
  endtask

  initial begin
    nRST       = 1'b0;
    fetch_req  = 1'b0;
    fetch_pc   = 32'h0;
    res_valid  = 1'b0;
    res_pc     = 32'h0;
    res_taken  = 1'b0;
    res_target = 32'h0;
    last_wsel  = '0;
    last_wtag  = '0;
    last_whist = '0;
    last_wtgt  = '0;
    fork
      monitor();
      storage_loop();
    join_none
    test_reset();
    test_predict_empty();
    test_alloc();
    test_saturate();
    test_miss_no_write();
    test_max_wait();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btb_controller.md
Name: btb_controller

Overview:
- Owns the 4-entry direct-mapped branch target buffer and drives both of its ports.
- Serves fetch-stage lookups from the read port and produces the taken/target prediction.
- Queues branch resolutions from the execute stage and applies each as a read-modify-write 2-bit saturating-counter update, stealing the read port from fetch when needed.
- Sits between fetch, execute and the BTB storage module.

Parameters:
- QDEPTH, 2, update queue depth (power of 2, >=2).
- MAX_WAIT, 8, cycles a queued update may wait for the read port before fetch is stalled to serve it.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch presents a valid PC this cycle.
- fetch_pc  in  32  fetch PC (word aligned).
- fetch_stall  out  1  read port granted to update; fetch must hold its PC.
- pred_taken  out  1  predict taken.
- pred_target  out  32  predicted next PC.
- res_valid  in  1  execute-stage branch resolution valid.
- res_ready  out  1  update queue can accept.
- res_pc  in  32  resolved branch PC.
- res_taken  in  1  actual direction.
- res_target  in  32  actual taken target.
- btb_sel  out  2  read index.
- btb_tag  out  28  read compare tag.
- btb_hit  in  1  read hit.
- btb_hist  in  2  read counter.
- btb_target  in  30  read target word address.
- btb_wen  out  1  write enable.
- btb_wsel  out  2  write index.
- btb_wtag  out  28  write tag.
- btb_wtarget  out  30  write target.
- btb_wvalid  out  1  write slot-enabled bit.
- btb_whist  out  2  write counter.

Behaviour:
- Address split: index = pc[3:2], tag = pc[31:4], target word = pc[31:2].
- Reset:
  - FSM to IDLE, queue empty, wait counter 0.
  - btb_wen=0, fetch_stall=0, pred_taken=0, res_ready=1.
  - All btb write fields 0.
- Prediction (combinational, same cycle):
  - When fetch owns the read port: btb_sel/btb_tag come from fetch_pc.
  - pred_taken = fetch_req & btb_hit & btb_hist[1].
  - pred_target = pred_taken ? {btb_target,2'b00} : fetch_pc+4 (mod 2^32).
- Queue:
  - res_ready = !full.
  - Push on res_valid & res_ready; entry = {index, tag, taken, res_target[31:2]}.
  - No push when full, even if a pop occurs the same cycle.
- FSM: IDLE -> RD -> WR|IDLE.
  - IDLE: enter RD next cycle when the queue is non-empty and (fetch_req=0 | queue full | wait counter == MAX_WAIT).
  - RD (one cycle):
    - Read port driven from the queue head.
    - fetch_stall = fetch_req; pred_taken=0.
    - Capture btb_hit/btb_hist/btb_target, then pop the head.
    - Go to WR unless (miss & !taken); in that case go to IDLE with no write.
  - WR (one cycle):
    - btb_wen=1, btb_wvalid=1, wsel/wtag from the captured entry.
    - Hit & taken: whist = sat_inc(hist), wtarget = res target.
    - Hit & !taken: whist = sat_dec(hist), wtarget = stored target.
    - Miss & taken (allocate/replace): whist = 2'b10, wtarget = res target.
    - Next state: IDLE. Fetch owns the read port in WR.
- Saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.
- Wait counter:
  - Increments each cycle in IDLE while the queue is non-empty and RD is not entered.
  - Saturates at MAX_WAIT; clears on RD entry.
- A fetch read in the same cycle as a WR to the same index sees the pre-write contents.
- Back-to-back updates to the same index serialize: the second RD follows the first WR, so it sees the new counter.
- Reset asserted mid-RD/WR: the write is aborted (btb_wen=0 immediately) and queued updates are discarded.

Decomposition:
- branch_pred_pkg contents:
  - btb_update_t {idx[1:0], tag[27:0], taken, target[29:0]}.
  - btb_state_t {IDLE, RD, WR}.
  - Functions sat_inc and sat_dec.
  - Constants for the index/tag bit ranges.
- Sub-module: btb_update_fifo, a parameterized synchronous FIFO with full/empty flags.

Test Plan:
- Reset, then fetch_pc=0x100 on an empty BTB -> pred_taken=0, pred_target=0x104, fetch_stall=0.
- Resolve pc=0x100, taken, target=0x200 with fetch idle -> RD then WR; write idx0, tag 0x0000010, whist=10, wtarget=0x080. Next fetch of 0x100 -> pred_taken=1, pred_target=0x200.
- Three further taken resolutions of 0x100 -> whist 11, 11, 11 (saturates). Then three not-taken -> 10, 01, 00. Fetch after the last -> pred_taken=0.
- Not-taken resolution of 0x300 on a miss -> no btb_wen pulse; FSM returns to IDLE after RD.
- Hold fetch_req=1 continuously, push one update -> fetch_stall stays 0 for MAX_WAIT=8 cycles, then exactly one stall cycle (RD), then WR.
- Push 2 updates while fetch is busy -> res_ready=0 when full; the RD grant comes the next cycle; updates to the same index 0x110/0x110 apply sequentially, giving final hist 11 from 10.
